// File: rtl/score_keeper_pkg.sv
// Shared definitions for the score keeper and its display/top-level neighbours.
//   game_state_t      : round state (IDLE, PLAYING, DONE)
//   SCORE_W           : width of the score bus driven to the 7-segment controller
//   DEFAULT_MAX_SCORE : default saturation value, keeps the display BCD-safe
//   sat_inc()         : increment that sticks at a ceiling instead of wrapping
package score_keeper_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        DONE    = 2'd2
    } game_state_t;

    localparam int SCORE_W           = 4;
    localparam int DEFAULT_MAX_SCORE = 9;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] value,
                                                   input logic [SCORE_W-1:0] ceiling);
        return (value >= ceiling) ? ceiling : value + 1'b1;
    endfunction

endpackage

// File: rtl/score_keeper_debouncer.sv
// Per-button conditioning: 2-FF synchroniser, stability debouncer, rising-edge pulse.
//   clock_100Mhz : system clock
//   reset_n      : synchronous reset, active-low
//   btn_raw      : raw asynchronous button, active-high
//   btn_level    : debounced button level
//   btn_pulse    : one-cycle registered pulse on each debounced press
module button_debouncer
    import score_keeper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock_100Mhz,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock_100Mhz) begin
        if (!reset_n) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            cnt       <= '0;
            btn_level <= 1'b0;
            level_d   <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
            // Level only follows the synced input after DEBOUNCE_CYCLES consecutive
            // disagreeing samples; any agreeing sample restarts the count.
            if (sync_2 != btn_level) begin
                if (cnt == CNT_LAST) begin
                    btn_level <= sync_2;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
            level_d   <= btn_level;
            btn_pulse <= btn_level & ~level_d;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Timed game round: debounced start/hit buttons, one-second tick, saturating score.
//   clock_100Mhz : system clock, the only clock
//   reset_n      : synchronous reset, active-low
//   btn_start    : raw start button, active-high
//   btn_hit      : raw hit button, active-high
//   score        : current score, 0..MAX_SCORE
//   game_active  : high while a round is running
//   game_over    : high once a round has finished, until the next start
//   seconds_left : remaining whole seconds in the round
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int GAME_SECONDS    = 10,
    parameter int MAX_SCORE       = DEFAULT_MAX_SCORE
) (
    input  logic               clock_100Mhz,
    input  logic               reset_n,
    input  logic               btn_start,
    input  logic               btn_hit,
    output logic [SCORE_W-1:0] score,
    output logic               game_active,
    output logic               game_over,
    output logic [3:0]         seconds_left
);

    localparam int                 TICK_W     = $clog2(CLK_HZ);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(CLK_HZ - 1);
    localparam logic [SCORE_W-1:0] SCORE_CEIL = SCORE_W'(MAX_SCORE);
    localparam logic [3:0]         SECS_INIT  = 4'(GAME_SECONDS);

    logic start_level;
    logic start_pulse;
    logic hit_level;
    logic hit_pulse;
    logic unused_levels;

    game_state_t       state;
    logic [TICK_W-1:0] tick_cnt;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_btn (
        .clock_100Mhz (clock_100Mhz),
        .reset_n      (reset_n),
        .btn_raw      (btn_start),
        .btn_level    (start_level),
        .btn_pulse    (start_pulse)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hit_btn (
        .clock_100Mhz (clock_100Mhz),
        .reset_n      (reset_n),
        .btn_raw      (btn_hit),
        .btn_level    (hit_level),
        .btn_pulse    (hit_pulse)
    );

    // Only the pulses drive the game; the levels are available for LEDs upstream.
    assign unused_levels = start_level ^ hit_level;

    always_ff @(posedge clock_100Mhz) begin
        if (!reset_n) begin
            state        <= IDLE;
            score        <= '0;
            seconds_left <= '0;
            tick_cnt     <= '0;
            game_active  <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // A simultaneous hit is dropped: the round starts from zero.
                    if (start_pulse) begin
                        state        <= PLAYING;
                        score        <= '0;
                        seconds_left <= SECS_INIT;
                        tick_cnt     <= '0;
                        game_active  <= 1'b1;
                        game_over    <= 1'b0;
                    end
                end
                PLAYING: begin
                    // Hit on the final tick still counts; score then freezes in DONE.
                    if (hit_pulse) begin
                        score <= sat_inc(score, SCORE_CEIL);
                    end
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        if (seconds_left == 4'd1) begin
                            state        <= DONE;
                            seconds_left <= '0;
                            game_active  <= 1'b0;
                            game_over    <= 1'b1;
                        end else begin
                            seconds_left <= seconds_left - 4'd1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    game_active <= 1'b0;
                    game_over   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Randomised and directed bench for score_keeper with a cycle-level reference model.
module tb_score_keeper;

    // One "second" is 40 cycles so a 3-second round is long enough for 12 debounced presses.
    localparam int CLK_HZ = 40;
    localparam int DB     = 4;
    localparam int GS     = 3;
    localparam int MAXS   = 9;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_hit = 1'b0;
    logic [3:0] score;
    logic       game_active;
    logic       game_over;
    logic [3:0] seconds_left;

    score_keeper #(
        .CLK_HZ          (CLK_HZ),
        .DEBOUNCE_CYCLES (DB),
        .GAME_SECONDS    (GS),
        .MAX_SCORE       (MAXS)
    ) dut (
        .clock_100Mhz (clk),
        .reset_n      (reset_n),
        .btn_start    (btn_start),
        .btn_hit      (btn_hit),
        .score        (score),
        .game_active  (game_active),
        .game_over    (game_over),
        .seconds_left (seconds_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        int score;
        bit active;
        bit over;
        int secs;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    // Reference model: a press is recognised when the raw button has read the same
    // new value on DB consecutive clock edges; its effect on the game lands 4 edges later.
    bit model_valid = 1'b0;
    int run_val [2];
    int run_len [2];
    bit lvl [2];
    bit pend [2][4];
    int m_state = 0;     // 0 idle, 1 playing, 2 done
    int m_score = 0;
    int m_elapsed = 0;   // edges since the round started

    always @(posedge clk) begin
        bit   ev  [2];
        bit   raw [2];
        exp_t e;
        cyc++;
        if (!reset_n) begin
            model_valid = 1'b1;
            m_state   = 0;
            m_score   = 0;
            m_elapsed = 0;
            for (int b = 0; b < 2; b++) begin
                run_val[b] = 0;
                run_len[b] = DB;
                lvl[b]     = 1'b0;
                for (int j = 0; j < 4; j++) pend[b][j] = 1'b0;
            end
        end else if (model_valid) begin
            raw[0] = btn_start;
            raw[1] = btn_hit;
            for (int b = 0; b < 2; b++) begin
                ev[b] = pend[b][0];
                for (int j = 0; j < 3; j++) pend[b][j] = pend[b][j+1];
                pend[b][3] = 1'b0;
                if (int'(raw[b]) == run_val[b]) run_len[b]++;
                else begin
                    run_val[b] = int'(raw[b]);
                    run_len[b] = 1;
                end
                if (run_len[b] == DB && run_val[b] != int'(lvl[b])) begin
                    lvl[b] = (run_val[b] != 0);
                    if (lvl[b]) pend[b][3] = 1'b1;
                end
            end
            if (m_state != 1) begin
                if (ev[0]) begin
                    m_state   = 1;
                    m_score   = 0;
                    m_elapsed = 0;
                end
            end else begin
                if (ev[1] && m_score < MAXS) m_score++;
                m_elapsed++;
                if (m_elapsed == GS * CLK_HZ) m_state = 2;
            end
        end
        if (model_valid) begin
            e.score  = m_score;
            e.active = (m_state == 1);
            e.over   = (m_state == 2);
            e.secs   = (m_state == 1) ? GS - m_elapsed / CLK_HZ : 0;
            sb.push_back(e);
        end
    end

    // Monitor: every clock the DUT presents a new registered output set.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (int'(score) != e.score || game_active !== e.active ||
                game_over !== e.over || int'(seconds_left) != e.secs) begin
                n_fail++;
                $display("FAIL outputs @cycle %0d: got score=%0d active=%0b over=%0b secs=%0d, expected score=%0d active=%0b over=%0b secs=%0d",
                         cyc, score, game_active, game_over, seconds_left,
                         e.score, e.active, e.over, e.secs);
            end
        end else if (model_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard @cycle %0d: no expected entry", cyc);
        end
    end

    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input bit s, input bit h, input int hi, input int lo);
        btn_start = s;
        btn_hit   = h;
        repeat (hi) step();
        btn_start = 1'b0;
        btn_hit   = 1'b0;
        repeat (lo) step();
    endtask

    task automatic wait_over();
        for (int i = 0; i < 300 && !game_over; i++) step();
        check_val("round end reached", int'(game_over), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int rem_s;
        int rem_h;

        // Reset held with buttons toggling
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            btn_start = ~btn_start;
            btn_hit   = (i == 1);
            step();
        end
        btn_start = 1'b0;
        btn_hit   = 1'b0;
        reset_n   = 1'b1;
        check_val("reset score", int'(score), 0);
        check_val("reset seconds_left", int'(seconds_left), 0);
        check_val("reset game_active", int'(game_active), 0);
        check_val("reset game_over", int'(game_over), 0);
        repeat (5) step();

        // Round with bouncing hit presses, then one clean press
        press(1, 0, 6, 4);
        check_val("start seconds_left", int'(seconds_left), GS);
        check_val("start game_active", int'(game_active), 1);
        for (int g = 1; g <= 3; g++) press(0, 1, g, 5);
        check_val("bounce score", int'(score), 0);
        press(0, 1, 6, 4);
        wait_over();
        check_val("bounce round score", int'(score), 1);
        check_val("done seconds_left", int'(seconds_left), 0);

        // Hit while DONE is ignored
        press(0, 1, 6, 4);
        check_val("hit in done score", int'(score), 1);

        // Saturation round
        press(1, 0, 6, 4);
        for (int i = 0; i < 12; i++) press(0, 1, 5, 4);
        wait_over();
        check_val("saturated score", int'(score), MAXS);
        press(0, 1, 6, 4);
        check_val("saturated hit in done", int'(score), MAXS);

        // Hit recognised on the final tick of the round
        p = cyc + 1;
        press(1, 0, 6, 4);
        press(0, 1, 5, 4);
        press(0, 1, 5, 4);
        while (cyc < p + 119) step();
        press(0, 1, 5, 4);
        wait_over();
        check_val("final tick hit score", int'(score), 3);

        // Start and hit together in DONE, start mid-round, reset mid-round
        press(1, 1, 6, 4);
        check_val("start+hit active", int'(game_active), 1);
        check_val("start+hit score", int'(score), 0);
        for (int i = 0; i < 5; i++) press(0, 1, 5, 4);
        press(1, 0, 6, 4);
        check_val("midround score", int'(score), 5);
        check_val("midround seconds_left", int'(seconds_left), 2);
        check_val("midround active", int'(game_active), 1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check_val("midreset score", int'(score), 0);
        check_val("midreset seconds_left", int'(seconds_left), 0);
        check_val("midreset active", int'(game_active), 0);
        check_val("midreset over", int'(game_over), 0);
        repeat (5) step();

        // Random button activity with occasional resets
        rem_s = 1;
        rem_h = 1;
        repeat (3000) begin
            if (rem_s == 0) begin
                btn_start = ~btn_start;
                rem_s = btn_start ? $urandom_range(1, 8) : $urandom_range(20, 150);
            end
            if (rem_h == 0) begin
                btn_hit = ~btn_hit;
                rem_h = $urandom_range(1, 10);
            end
            reset_n = ($urandom_range(0, 399) != 0);
            rem_s--;
            rem_h--;
            step();
        end
        reset_n   = 1'b1;
        btn_start = 1'b0;
        btn_hit   = 1'b0;
        repeat (10) step();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
